// File: rtl/craft_pkg.sv
// ---------------------------------------------------------------------------
// craft_pkg
// Shared constants and types for the iterative CRAFT-64 encryption core.
//   SBOX  : 4-bit S-box applied to every nibble
//   PN    : nibble permutation, y[PN[j]] = x[j]
//   Q     : tweak nibble permutation, Q(T)[j] = T[Q[j]]
//   RC4/3 : round-constant LFSR sequences, one entry per round (32 rounds)
//   state_t : control FSM states
// Nibble 0 of any 64-bit word is bits 63:60.
// ---------------------------------------------------------------------------
package craft_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
    };

    localparam logic [3:0] PN [16] = '{
        4'd15, 4'd12, 4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd11,
        4'd6,  4'd5,  4'd4,  4'd7,  4'd1,  4'd2, 4'd3, 4'd0
    };

    localparam logic [3:0] Q [16] = '{
        4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9,  4'd2,
        4'd11, 4'd3,  4'd7,  4'd4, 4'd6,  4'd0, 4'd1,  4'd13
    };

    localparam logic [3:0] RC4 [32] = '{
        4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hc, 4'h6, 4'hb,
        4'h5, 4'ha, 4'hd, 4'he, 4'hf, 4'h7, 4'h3, 4'h1,
        4'h8, 4'h4, 4'h2, 4'h9, 4'hc, 4'h6, 4'hb, 4'h5,
        4'ha, 4'hd, 4'he, 4'hf, 4'h7, 4'h3, 4'h1, 4'h8
    };

    localparam logic [3:0] RC3 [32] = '{
        4'h1, 4'h4, 4'h2, 4'h5, 4'h6, 4'h7, 4'h3, 4'h1,
        4'h4, 4'h2, 4'h5, 4'h6, 4'h7, 4'h3, 4'h1, 4'h4,
        4'h2, 4'h5, 4'h6, 4'h7, 4'h3, 4'h1, 4'h4, 4'h2,
        4'h5, 4'h6, 4'h7, 4'h3, 4'h1, 4'h4, 4'h2, 4'h5
    };

    // Gather form: output nibble j takes input nibble Q[j].
    function automatic logic [63:0] q_perm(input logic [63:0] t);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            y[63-4*j -: 4] = t[63-4*int'(Q[j]) -: 4];
        end
        return y;
    endfunction

endpackage

// File: rtl/craft_iter_core_if.sv
// ---------------------------------------------------------------------------
// craft_iter_core_if
// Handshake bundle between a host/mode layer (master) and the CRAFT core
// (slave).
//   in_valid/in_ready   : input tuple handshake (plaintext, tweak, key)
//   out_valid/out_ready : ciphertext handshake with backpressure
//   busy                : core is iterating rounds
// ---------------------------------------------------------------------------
interface craft_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  plaintext;
    logic [63:0]  tweak;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  ciphertext;
    logic         busy;

    modport master (
        output in_valid, plaintext, tweak, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, tweak, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

// File: rtl/craft_round.sv
// ---------------------------------------------------------------------------
// craft_round
// One combinational CRAFT round: MixColumn, AddConstants, AddTweakey, then
// (unless this is the final round) PermuteNibbles and SubBox.
//   i_state   : 64-bit state entering the round
//   i_rk      : tweakey TK[i mod 4] for this round
//   i_round   : global round index i (selects the round constants)
//   i_is_last : final round of the cipher, PN/SB skipped
//   o_state   : state after the round
// ---------------------------------------------------------------------------
module craft_round
    import craft_pkg::*;
#(
    parameter int CW = 6
) (
    input  logic [63:0]   i_state,
    input  logic [63:0]   i_rk,
    input  logic [CW-1:0] i_round,
    input  logic          i_is_last,
    output logic [63:0]   o_state
);
    logic [3:0]  w_x   [16];
    logic [3:0]  w_mc  [16];
    logic [3:0]  w_pn  [16];
    logic [3:0]  w_sb  [16];
    logic [63:0] w_mc_flat;
    logic [63:0] w_atk;
    logic [63:0] w_sb_flat;
    logic [4:0]  w_ridx;

    // Constant tables hold 32 entries; the round index never exceeds 31.
    assign w_ridx = 5'(i_round);

    for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
        assign w_x[gi] = i_state[63-4*gi -: 4];
    end

    // MixColumn per column: row0 ^= row2 ^ row3, row1 ^= row3.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mc
        assign w_mc[gi]      = w_x[gi] ^ w_x[8+gi] ^ w_x[12+gi];
        assign w_mc[4+gi]    = w_x[4+gi] ^ w_x[12+gi];
        assign w_mc[8+gi]    = w_x[8+gi];
        assign w_mc[12+gi]   = w_x[12+gi];
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_pack_mc
        assign w_mc_flat[63-4*gi -: 4] = w_mc[gi];
    end

    // Round constants land on nibbles 4 (bits 47:44) and 5 (bits 43:40).
    assign w_atk = w_mc_flat
                 ^ {16'h0, RC4[w_ridx], RC3[w_ridx], 40'h0}
                 ^ i_rk;

    for (genvar gi = 0; gi < 16; gi++) begin : g_pn_sb
        assign w_pn[PN[gi]] = w_atk[63-4*gi -: 4];
        craft_sbox u_sbox (
            .i_x (w_pn[gi]),
            .o_y (w_sb[gi])
        );
        assign w_sb_flat[63-4*gi -: 4] = w_sb[gi];
    end

    assign o_state = i_is_last ? w_atk : w_sb_flat;
endmodule

// File: rtl/craft_sbox.sv
// ---------------------------------------------------------------------------
// craft_sbox
// Combinational 4-bit CRAFT S-box.
//   i_x : input nibble
//   o_y : substituted nibble
// ---------------------------------------------------------------------------
module craft_sbox
    import craft_pkg::*;
(
    input  logic [3:0] i_x,
    output logic [3:0] o_y
);
    assign o_y = SBOX[i_x];
endmodule

// File: rtl/craft_iter_core.sv
// ---------------------------------------------------------------------------
// craft_iter_core
// Iterative CRAFT-64 encryption core (64-bit block, 64-bit tweak, 128-bit
// key), UNROLL rounds per clock, valid/ready on both sides.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : craft_iter_core_if slave
//         in_valid/in_ready, plaintext, tweak, key (K0 = key[127:64])
//         out_valid/out_ready, ciphertext (stable while stalled), busy
// Parameters:
//   ROUNDS : total rounds, multiple of UNROLL, 4..32
//   UNROLL : rounds per clock, 1/2/4/8
//   CW     : round-counter width, 2**CW > ROUNDS
// ---------------------------------------------------------------------------
module craft_iter_core
    import craft_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int UNROLL = 1,
    parameter int CW     = 6
) (
    input  logic             clk,
    input  logic             rst,
    craft_iter_core_if.slave bus
);
    state_t        r_fsm;
    state_t        w_fsm_next;
    logic [63:0]   r_blk;
    logic [63:0]   r_ct;
    logic [63:0]   r_tk [4];
    logic [CW-1:0] r_cnt;
    logic          r_out_valid;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_last_grp;
    logic [63:0]   w_tq;
    logic [63:0]   w_chain [UNROLL+1];

    // The counter is compared against ROUNDS directly, so it never relies
    // on wrapping at 2**CW.
    assign w_last_grp = (r_cnt == CW'(ROUNDS - UNROLL));
    assign w_tq       = q_perm(bus.tweak);

    // Unrolled round chain; the final-round decision uses the global index,
    // so it works wherever ROUNDS-1 falls inside the group.
    assign w_chain[0] = r_blk;
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
        logic [CW-1:0] w_idx;
        assign w_idx = r_cnt + CW'(gi);
        craft_round #(.CW(CW)) u_round (
            .i_state   (w_chain[gi]),
            .i_rk      (r_tk[w_idx[1:0]]),
            .i_round   (w_idx),
            .i_is_last (w_idx == CW'(ROUNDS - 1)),
            .o_state   (w_chain[gi+1])
        );
    end

    // Next-state and handshake decode.
    always_comb begin
        w_fsm_next = r_fsm;
        w_in_ready = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_fsm_next = S_RUN;
            end
            S_RUN: begin
                if (w_last_grp) w_fsm_next = S_HOLD;
            end
            S_HOLD: begin
                // Draining the result frees the core in the same cycle,
                // letting a waiting tuple start without an IDLE bubble.
                w_in_ready = bus.out_ready;
                if (bus.out_ready) w_fsm_next = bus.in_valid ? S_RUN : S_IDLE;
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_blk       <= '0;
            r_ct        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < 4; k++) r_tk[k] <= '0;
        end else begin
            r_fsm <= w_fsm_next;

            if (w_accept) begin
                r_blk   <= bus.plaintext;
                r_tk[0] <= bus.key[127:64] ^ bus.tweak;
                r_tk[1] <= bus.key[63:0]   ^ bus.tweak;
                r_tk[2] <= bus.key[127:64] ^ w_tq;
                r_tk[3] <= bus.key[63:0]   ^ w_tq;
                r_cnt   <= '0;
            end else if (r_fsm == S_RUN) begin
                r_blk <= w_chain[UNROLL];
                r_cnt <= r_cnt + CW'(UNROLL);
            end

            if (r_fsm == S_RUN && w_last_grp) begin
                r_ct        <= w_chain[UNROLL];
                r_out_valid <= 1'b1;
            end else if (r_fsm == S_HOLD && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.ciphertext = r_ct;
    assign bus.busy       = (r_fsm == S_RUN);
endmodule
